// File: rtl/bm_pkg.sv
// Shared constants, types and segment/offset helpers for the Box-Muller g(u2) sin/cos stage.
// Build option BM_SINCOS_ROUND_EN (see bm_cg_interp) selects round-half-up interpolation.
package bm_pkg;

    localparam int U_W   = 16;
    localparam int C_W   = 19;
    localparam int G_W   = 12;
    localparam int OUT_W = 20;
    localparam int SEG_W = 7;
    localparam int OFF_W = 7;
    localparam int ROM_W = C_W + G_W;

    typedef logic [1:0] quad_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_S,
        CALC_C,
        CALC_S,
        OUT
    } state_t;

    // cos reads the quarter wave mirrored in odd quadrants, sin in even ones;
    // mirroring the 14-bit index is a bitwise invert of both segment and offset.
    function automatic logic [SEG_W-1:0] seg_addr(input logic [U_W-1:0] u, input logic is_sin);
        return (u[U_W-2] ^ is_sin) ? ~u[U_W-3 -: SEG_W] : u[U_W-3 -: SEG_W];
    endfunction

    function automatic logic [OFF_W-1:0] seg_offset(input logic [U_W-1:0] u, input logic is_sin);
        return (u[U_W-2] ^ is_sin) ? ~u[OFF_W-1:0] : u[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/bm_cg_interp.sv
// Linear interpolation of one quarter-wave ROM entry plus sign application.
// Defining BM_SINCOS_ROUND_EN rounds the gradient step half-up instead of truncating it.
module bm_cg_interp
    import bm_pkg::*;
(
    input  logic [ROM_W-1:0]        rdata,
    input  logic [OFF_W-1:0]        offset,
    input  logic                    neg,
    output logic signed [OUT_W-1:0] result
);

    localparam int P_W = G_W + OFF_W + 1;

    function automatic logic [C_W-1:0] grad_step(input logic [G_W-1:0] g, input logic [OFF_W-1:0] off);
        logic [P_W-1:0] p;
        p = P_W'(g) * P_W'(off);
`ifdef BM_SINCOS_ROUND_EN
        p = p + (P_W'(1) << (OFF_W - 1));
`else
        p = p;
`endif
        return C_W'(p >> OFF_W);
    endfunction

    // Near the zero crossing the step can exceed the base; the magnitude floors at 0.
    function automatic logic [C_W-1:0] sub_clamp(input logic [C_W-1:0] c, input logic [C_W-1:0] d);
        return (d > c) ? '0 : (c - d);
    endfunction

    logic [C_W-1:0]          base;
    logic [C_W-1:0]          step;
    logic [C_W-1:0]          mag;
    logic signed [OUT_W-1:0] mag_s;

    always_comb begin
        base   = rdata[ROM_W-1:G_W];
        step   = grad_step(rdata[G_W-1:0], offset);
        mag    = sub_clamp(base, step);
        mag_s  = signed'(OUT_W'(mag));
        result = neg ? -mag_s : mag_s;
    end

endmodule

// File: rtl/bm_sincos_eval.sv
// Box-Muller g(u2): cos/sin of 2*pi*u2 via one time-shared ROM port, cos lookup then sin.
// Build option BM_SINCOS_ROUND_EN selects round-half-up interpolation (default truncates).
module bm_sincos_eval
    import bm_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [U_W-1:0]          u2,
    output logic [SEG_W-1:0]        rom_addr,
    input  logic [ROM_W-1:0]        rom_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] cos_out,
    output logic signed [OUT_W-1:0] sin_out
);

    state_t                  state;
    state_t                  state_nx;
    logic [U_W-1:0]          u2_p0;
    quad_t                   q_p0;
    logic                    accept;
    logic                    calc_sin;
    logic [OFF_W-1:0]        off_sel;
    logic                    neg_sel;
    logic signed [OUT_W-1:0] interp_y;

    assign q_p0     = u2_p0[U_W-1 -: 2];
    assign in_ready = (state == IDLE) | ((state == OUT) & out_ready);
    assign accept   = in_valid & in_ready;
    assign calc_sin = (state == CALC_S);
    assign off_sel  = seg_offset(u2_p0, calc_sin);
    assign neg_sel  = calc_sin ? q_p0[1] : (q_p0[1] ^ q_p0[0]);

    bm_cg_interp u_interp (
        .rdata  (rom_rdata),
        .offset (off_sel),
        .neg    (neg_sel),
        .result (interp_y)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ADDR_S;
            ADDR_S:  state_nx = CALC_C;
            CALC_C:  state_nx = CALC_S;
            CALC_S:  state_nx = OUT;
            OUT:     if (out_ready) state_nx = accept ? ADDR_S : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Stage p0: sample capture and ROM addressing (cos segment on accept, sin segment next)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            u2_p0    <= '0;
            rom_addr <= '0;
        end else if (accept) begin
            u2_p0    <= u2;
            rom_addr <= seg_addr(u2, 1'b0);
        end else if (state == ADDR_S) begin
            rom_addr <= seg_addr(u2_p0, 1'b1);
        end
    end

    // Stage p1: ROM data arrives one cycle after its address; cos first, then sin
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cos_out   <= '0;
            sin_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == CALC_C) begin
                cos_out <= interp_y;
            end
            if (state == CALC_S) begin
                sin_out   <= interp_y;
                out_valid <= 1'b1;
            end else if ((state == OUT) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bm_sincos_eval.sv
// Scoreboard bench for bm_sincos_eval with a small behavioural model of the bm_cg_rom port.
// Expected values are hand-computed against the ROM contents defined in rom_word().
module tb_bm_sincos_eval;

`ifdef BM_SINCOS_ROUND_EN
    localparam int TAIL = 25;
`else
    localparam int TAIL = 26;
`endif

    logic               clock;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        u2;
    logic [6:0]         rom_addr;
    logic [30:0]        rom_rdata;
    logic               out_valid;
    logic               out_ready;
    logic signed [19:0] cos_out;
    logic signed [19:0] sin_out;

    typedef struct {
        int c;
        int s;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    bm_sincos_eval dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .u2        (u2),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Entries 0 and 127 match the real table ends; 100 forces the clamp; others are linear.
    function automatic logic [30:0] rom_word(input logic [6:0] a);
        logic [18:0] c;
        logic [11:0] g;
        case (a)
            7'd0:    begin c = 19'd262146; g = 12'd20;   end
            7'd127:  begin c = 19'd3217;   g = 12'd3217; end
            7'd100:  begin c = 19'd100;    g = 12'd4095; end
            default: begin c = 19'(262144 - int'(a) * 2048); g = 12'd2048; end
        endcase
        return {c, g};
    endfunction

    always @(posedge clock) rom_rdata <= rom_word(rom_addr);

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a result transfers on the next posedge whenever valid and ready are both high.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("cos_out", cos_out, e.c);
                check("sin_out", sin_out, e.s);
            end
        end
    end

    task automatic issue(input logic [15:0] v, input int c, input int s);
        int   g;
        exp_t e;
        in_valid = 1'b1;
        u2       = v;
        g        = 0;
        @(negedge clock);
        while (!in_ready && g < 64) begin
            @(negedge clock);
            g++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        e.c = c;
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 32) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(posedge clock);
            g++;
        end
        #1;
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int n;
        int bad;
        int seen;
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        u2        = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_cos", cos_out, 0);
        check("rst_sin", sin_out, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // The accepting edge counts as the first; out_valid rises on the fourth.
        issue(16'h0000, 262146, TAIL);
        wait_valid(n);
        check("latency", n, 3);

        issue(16'h0040, 262136, 1634);
        check("rom_addr_cos", rom_addr, 0);
        @(posedge clock);
        #1;
        check("rom_addr_sin", rom_addr, 127);

        issue(16'h4000, -TAIL, 262146);
        issue(16'h8000, -262146, -TAIL);
        issue(16'hC000, TAIL, -262146);
        issue(16'h1234, 187584, 74576);
        issue(16'h5234, -74576, 187584);
        issue(16'h327F, 0, 206848);
        issue(16'hB27F, 0, -206848);
        drain();

        out_ready = 1'b0;
        issue(16'h8000, -262146, -TAIL);
        wait_valid(n);
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (!out_valid || cos_out != -262146 || sin_out != -TAIL || in_ready) bad++;
        end
        check("hold_stable", bad, 0);
        check("hold_in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        issue(16'hC000, TAIL, -262146);
        wait_valid(n);
        check("b2b_latency", n, 3);
        drain();

        issue(16'h1234, 187584, 74576);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_cos", cos_out, 0);
        check("abort_sin", sin_out, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("no_ghost_result", seen, 0);

        @(posedge clock);
        #1;
        issue(16'h0040, 262136, 1634);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

endmodule
